inst_encoder: RTL and testbench

Packs RISC-V instruction fields (format, opcode, funct3/funct7, register indices, 32-bit immediate) into 32-bit instruction words and writes them sequentially into instruction memory. It performs the exact inverse of the instruction-decode stage's R/I/S/B/U/J immediate and field extraction. It sits between the test/boot loader and IMEM, and is used to build programs in-system. It is a two-stage pipeline with a valid/ready input handshake, memory-side backpressure, an auto-incrementing write address and sticky encode-error reporting.

---
 rtl/inst_encoder.sv | 137 +++++++++++++
 tb/tb_inst_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: packs RISC-V instruction fields into 32-bit words and streams them
// into IMEM through a two-stage pipeline with sticky encode-error reporting.
module inst_encoder #(
    parameter int RFW = 5,
    parameter int DW  = 32,
    parameter int IW  = 32,
    parameter int AW  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [AW-1:0]  base_addr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     fmt,
    input  logic [4:0]     opcode,
    input  logic [2:0]     funct3,
    input  logic [6:0]     funct7,
    input  logic [RFW-1:0] rd,
    input  logic [RFW-1:0] rs1,
    input  logic [RFW-1:0] rs2,
    input  logic [DW-1:0]  imm,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [IW-1:0]  mem_wdata,
    input  logic           mem_ready,
    output logic [AW:0]    count,
    output logic           busy,
    output logic           err,
    output logic [1:0]     err_code
);
    typedef struct packed {
        logic [2:0]     fmt;
        logic [4:0]     opcode;
        logic [2:0]     funct3;
        logic [6:0]     funct7;
        logic [RFW-1:0] rd;
        logic [RFW-1:0] rs1;
        logic [RFW-1:0] rs2;
        logic [DW-1:0]  imm;
    } bundle_t;

    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    bundle_t       in_bundle, s1;
    logic          s1_valid, s2_valid;
    logic [6:0]    op;
    logic [IW-1:0] enc_word;
    logic [1:0]    enc_code;
    logic          ok11, ok12, ok20;
    logic          s1_bad, s2_done, s1_drain, s1_move, s2_load, accept, start_ok;

    assign in_bundle = {fmt, opcode, funct3, funct7, rd, rs1, rs2, imm};

    // An immediate fits when every bit above the encoded field is a copy of the sign.
    assign ok11 = (&s1.imm[31:11]) | ~(|s1.imm[31:11]);
    assign ok12 = (&s1.imm[31:12]) | ~(|s1.imm[31:12]);
    assign ok20 = (&s1.imm[31:20]) | ~(|s1.imm[31:20]);
    assign op   = {s1.opcode, 2'b11};

    always_comb begin
        enc_word = '0;
        enc_code = 2'd0;
        case (s1.fmt)
            3'd0: enc_word = {s1.funct7, s1.rs2, s1.rs1, s1.funct3, s1.rd, op};
            3'd1: begin
                enc_word = {s1.imm[11:0], s1.rs1, s1.funct3, s1.rd, op};
                if (!ok11) enc_code = 2'd2;
            end
            3'd2: begin
                enc_word = {s1.imm[11:5], s1.rs2, s1.rs1, s1.funct3, s1.imm[4:0], op};
                if (!ok11) enc_code = 2'd2;
            end
            3'd3: begin
                enc_word = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, s1.funct3,
                            s1.imm[4:1], s1.imm[11], op};
                if (!ok12)          enc_code = 2'd2;
                else if (s1.imm[0]) enc_code = 2'd3;
            end
            3'd4: begin
                enc_word = {s1.imm[31:12], s1.rd, op};
                if (|s1.imm[11:0]) enc_code = 2'd2;
            end
            3'd5: begin
                enc_word = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12], s1.rd, op};
                if (!ok20)          enc_code = 2'd2;
                else if (s1.imm[0]) enc_code = 2'd3;
            end
            default: enc_code = 2'd1;
        endcase
    end

    // A bad word in S1 is discarded unconditionally, so it never stalls the input.
    assign s2_done  = s2_valid & mem_ready;
    assign s1_bad   = s1_valid & (enc_code != 2'd0);
    assign s1_drain = !s2_valid | s2_done | s1_bad;
    assign s1_move  = s1_valid & s1_drain;
    assign s2_load  = s1_move & !s1_bad;
    assign in_ready = !start & (!s1_valid | s1_drain);
    assign accept   = in_valid & in_ready;
    assign busy     = s1_valid | s2_valid;
    assign start_ok = start & !busy;
    assign mem_we   = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            if (accept) s1 <= in_bundle;
            s1_valid <= accept | (s1_valid & !s1_drain);
            s2_valid <= s2_load | (s2_valid & !s2_done);
            if (s2_load) mem_wdata <= enc_word;
            if (start_ok) begin
                mem_addr <= base_addr;
                count    <= '0;
                err      <= 1'b0;
                err_code <= 2'd0;
            end else begin
                if (s2_done) begin
                    mem_addr <= mem_addr + AW'(1);
                    if (count != CNT_MAX) count <= count + (AW+1)'(1);
                end
                if (s1_bad) begin
                    err <= 1'b1;
                    if (err_code == 2'd0) err_code <= enc_code;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: transaction-level model (write queue, error pending slot)
// checked every cycle, plus directed literal expectations and randomized traffic.
module tb_inst_encoder;
    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0, mem_ready = 1'b1;
    logic [9:0]  base_addr = '0;
    logic        in_ready, mem_we, busy, err;
    logic [2:0]  fmt = '0, funct3 = '0;
    logic [4:0]  opcode = '0, rd = '0, rs1 = '0, rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0, mem_wdata;
    logic [9:0]  mem_addr;
    logic [10:0] count;
    logic [1:0]  err_code;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .count(count), .busy(busy), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] BND [10] = '{32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF,
        32'hFFE, 32'hFFFFF000, 32'h1000, 32'hFFFFE, 32'hFFF00000, 32'h100000};

    typedef struct { logic [31:0] data; int acc; } exp_t;
    typedef struct { logic [9:0] addr; logic [31:0] data; int wedge; } wr_t;

    int errors = 0, checks = 0, edge_cnt = 0, hold = 0;
    bit mr_rand = 0;
    exp_t q[$];
    wr_t  wlog[$];
    logic [9:0]  m_addr = '0;
    logic [10:0] m_cnt = '0;
    logic        m_err = 1'b0, pend = 1'b0;
    logic [1:0]  m_code = '0, pend_code = '0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", n, a, e, $time);
        end
    endtask

    // Error code from the value ranges each format can represent.
    function automatic logic [1:0] mcode(input logic [2:0] f, input logic [31:0] im);
        longint s;
        s = longint'($signed(im));
        case (f)
            3'd0: return 2'd0;
            3'd1, 3'd2: return (s < -2048 || s > 2047) ? 2'd2 : 2'd0;
            3'd3: if (s < -4096 || s > 4095) return 2'd2; else return im[0] ? 2'd3 : 2'd0;
            3'd4: return (im % 32'd4096 != 0) ? 2'd2 : 2'd0;
            3'd5: if (s < -1048576 || s > 1048575) return 2'd2; else return im[0] ? 2'd3 : 2'd0;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [31:0] menc(input logic [2:0] f, input logic [4:0] op,
            input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
            input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] im);
        logic [31:0] w;
        w = 32'd0;
        w[6:2] = op;
        w[1:0] = 2'b11;
        case (f)
            3'd0: begin w[11:7] = d; w[14:12] = f3; w[19:15] = a1; w[24:20] = a2; w[31:25] = f7; end
            3'd1: begin w[11:7] = d; w[14:12] = f3; w[19:15] = a1; w[31:20] = im[11:0]; end
            3'd2: begin w[11:7] = im[4:0]; w[14:12] = f3; w[19:15] = a1; w[24:20] = a2; w[31:25] = im[11:5]; end
            3'd3: begin
                w[7] = im[11]; w[11:8] = im[4:1]; w[14:12] = f3; w[19:15] = a1;
                w[24:20] = a2; w[30:25] = im[10:5]; w[31] = im[12];
            end
            3'd4: begin w[11:7] = d; w[31:12] = im[31:12]; end
            default: begin
                w[11:7] = d; w[19:12] = im[19:12]; w[20] = im[11]; w[30:21] = im[10:1]; w[31] = im[20];
            end
        endcase
        return w;
    endfunction

    always @(posedge clk) edge_cnt++;

    // Check state after the last edge, then advance the model over the coming edge.
    always @(negedge clk) begin : mon
        bit ew, er, mb;
        logic [1:0] c;
        if (!rst_n) begin
            q.delete(); m_addr = '0; m_cnt = '0; m_err = 1'b0; m_code = '0; pend = 1'b0;
        end else begin
            mb = (q.size() > 0) || pend;
            ew = (q.size() > 0) && (q[0].acc < edge_cnt);
            er = !start && !(q.size() >= 2 && !mem_ready);
            chk("mem_we", 64'(mem_we), 64'(ew));
            if (ew) begin
                chk("mem_addr", 64'(mem_addr), 64'(m_addr));
                chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
            end
            chk("count", 64'(count), 64'(m_cnt));
            chk("err", 64'(err), 64'(m_err));
            chk("err_code", 64'(err_code), 64'(m_code));
            chk("busy", 64'(busy), 64'(mb));
            chk("in_ready", 64'(in_ready), 64'(er));
            if (pend) begin
                m_err = 1'b1;
                if (m_code == 2'd0) m_code = pend_code;
                pend = 1'b0;
            end
            if (start && !mb) begin
                m_addr = base_addr; m_cnt = '0; m_err = 1'b0; m_code = '0;
            end
            if (ew && mem_ready) begin
                wlog.push_back('{mem_addr, mem_wdata, edge_cnt + 1});
                void'(q.pop_front());
                m_addr = m_addr + 10'd1;
                if (m_cnt < 11'd1024) m_cnt = m_cnt + 11'd1;
            end
            if (in_valid && er) begin
                c = mcode(fmt, imm);
                if (c != 2'd0) begin pend = 1'b1; pend_code = c; end
                else q.push_back('{menc(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm), edge_cnt + 1});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (hold > 0) begin mem_ready = 1'b0; hold--; end
        else mem_ready = mr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] op, input logic [2:0] f3,
            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2,
            input logic [31:0] im, input bit st, input logic [9:0] ba);
        bit r;
        r = 0;
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = a1; rs2 = a2; imm = im;
        start = st; base_addr = ba; in_valid = 1'b1;
        for (int i = 0; i < 200 && !r; i++) begin
            @(negedge clk);
            r = in_ready;
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
        if (!r) chk("accept_timeout", 64'(r), 64'd1);
    endtask

    task automatic addi(input int r, input int v);
        send(3'd1, 5'b00100, 3'd0, 7'd0, 5'(r), 5'd0, 5'd0, 32'(v), 1'b0, 10'd0);
    endtask

    task automatic do_start(input logic [9:0] ba);
        start = 1'b1; base_addr = ba;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (busy && i < 200) begin tick(); i++; end
        chk("drain", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic wchk(input string n, input int idx, input logic [9:0] a, input logic [31:0] d);
        if (idx >= wlog.size()) chk({n, "_present"}, 64'(wlog.size()), 64'(idx + 1));
        else begin
            chk({n, "_addr"}, 64'(wlog[idx].addr), 64'(a));
            chk({n, "_data"}, 64'(wlog[idx].data), 64'(d));
        end
    endtask

    task automatic rnd_send();
        logic [31:0] im;
        logic [2:0] f;
        f = ($urandom % 16 == 0) ? 3'(6 + $urandom % 2) : 3'($urandom % 6);
        case ($urandom % 5)
            0: im = $urandom;
            1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: im = BND[$urandom % 10];
            3: im = $urandom & 32'hFFFFF000;
            default: im = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        endcase
        send(f, 5'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), im, ($urandom % 30 == 0), 10'($urandom));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Model pins
        chk("pin_addi", 64'(menc(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5)), 64'h00500093);
        chk("pin_beq", 64'(menc(3'd3, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC)), 64'hFE208EE3);
        chk("pin_code_i", 64'(mcode(3'd1, 32'd2048)), 64'd2);
        chk("pin_code_b", 64'(mcode(3'd3, 32'd3)), 64'd3);

        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        send(3'd7, 5'd3, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 10'd0);
        tick(); tick();
        chk("badfmt_err", 64'(err), 64'd1);
        chk("badfmt_code", 64'(err_code), 64'd1);
        do_start(10'h010);
        chk("start_addr", 64'(mem_addr), 64'h010);
        chk("start_count", 64'(count), 64'd0);
        chk("start_err", 64'(err), 64'd0);

        n = wlog.size();
        addi(1, 5);
        drain();
        wchk("addi", n, 10'h010, 32'h00500093);
        chk("addi_count", 64'(count), 64'd1);

        n = wlog.size();
        send(3'd0, 5'b01100, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 10'd0);
        send(3'd2, 5'b01000, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 10'd0);
        send(3'd3, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 10'd0);
        send(3'd4, 5'b01101, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 10'd0);
        send(3'd5, 5'b11011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0, 10'd0);
        drain();
        wchk("add", n, 10'h011, 32'h002081B3);
        wchk("sw", n + 1, 10'h012, 32'h0020A423);
        wchk("beq", n + 2, 10'h013, 32'hFE208EE3);
        wchk("lui", n + 3, 10'h014, 32'h123452B7);
        wchk("jal", n + 4, 10'h015, 32'h008000EF);
        for (int i = 1; i < 5; i++)
            if (n + i < wlog.size())
                chk("b2b_spacing", 64'(wlog[n + i].wedge - wlog[n + i - 1].wedge), 64'd1);

        n = wlog.size();
        addi(1, 1);
        hold = 5;
        addi(2, 2); addi(3, 3); addi(4, 4);
        drain();
        for (int i = 0; i < 4; i++)
            wchk("bp", n + i, 10'(10'h016 + i), 32'(((i + 1) << 20) | ((i + 1) << 7) | 32'h13));
        chk("bp_count", 64'(count), 64'd10);

        send(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 10'd0);
        tick(); tick();
        chk("range_err", 64'(err), 64'd1);
        chk("range_code", 64'(err_code), 64'd2);
        chk("range_addr", 64'(mem_addr), 64'h01A);
        send(3'd3, 5'b11000, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 10'd0);
        tick(); tick();
        chk("sticky_code", 64'(err_code), 64'd2);
        n = wlog.size();
        addi(7, 7);
        drain();
        wchk("after_err", n, 10'h01A, 32'h00700393);

        n = wlog.size();
        hold = 4;
        addi(9, 9);
        do_start(10'h100);
        drain();
        wchk("busy_start", n, 10'h01B, 32'h00900493);
        chk("busy_start_addr", 64'(mem_addr), 64'h01C);
        chk("busy_start_err", 64'(err), 64'd1);

        n = wlog.size();
        send(3'd1, 5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 10'h3FF);
        addi(2, 2);
        drain();
        wchk("wrap0", n, 10'h3FF, 32'h00100093);
        wchk("wrap1", n + 1, 10'h000, 32'h00200113);
        chk("wrap_count", 64'(count), 64'd2);
        chk("wrap_err", 64'(err), 64'd0);

        do_start(10'h000);
        repeat (1030) addi(int'($urandom_range(0, 31)), int'($urandom_range(0, 2047)));
        drain();
        chk("sat_count", 64'(count), 64'd1024);
        chk("sat_addr", 64'(mem_addr), 64'd6);

        mr_rand = 1;
        repeat (500) begin
            if ($urandom % 25 == 0) do_start(10'($urandom));
            if ($urandom % 4 == 0) tick();
            rnd_send();
        end
        mr_rand = 0;
        drain();

        hold = 20;
        addi(1, 1);
        addi(2, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_we", 64'(mem_we), 64'd0);
        chk("midrst_addr", 64'(mem_addr), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        hold = 0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n = wlog.size();
        addi(3, 3);
        drain();
        wchk("post_rst", n, 10'h000, 32'h00300193);
        chk("post_rst_count", 64'(count), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
